// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display counters: digit width,
// count direction codes and the active-low {g,f,e,d,c,b,a} glyph table.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyphs 0..F; entries A..F stay defined even for decimal counters
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/bcd_updown_display_counter.sv
// Multi-digit decimal/hex up/down counter with prescaler, load and 7-seg outputs.
// Optional macro UPDOWN_SATURATE_EN adds sat_mode to hold at the count limits.
module bcd_updown_display_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int RADIX     = 10,
    parameter int DIV_COUNT = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      dir,
`ifdef UPDOWN_SATURATE_EN
    input  logic                      sat_mode,
`endif
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      tick,
    output logic                      wrap,
    output logic [7*DIGITS-1:0]       seg
);

    localparam int CW = DIGIT_W * DIGITS;
    localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(DIV_COUNT - 1);
    localparam logic [DIGIT_W-1:0] MAX_DIGIT  = DIGIT_W'(RADIX - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;

    logic [CW-1:0]      stepped;
    logic [CW-1:0]      loaded;
    logic [DIGIT_W-1:0] cur;
    logic               carry;
    logic               all_max;
    logic               all_zero;
    logic               at_limit;
    logic               hold;

    // Ripple the carry (up) or borrow (down) from digit 0 upward
    always_comb begin
        stepped  = count_q;
        loaded   = load_val;
        cur      = '0;
        carry    = 1'b1;
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            cur      = count_q[i*DIGIT_W +: DIGIT_W];
            all_max  = all_max & (cur == MAX_DIGIT);
            all_zero = all_zero & (cur == '0);
            if (carry) begin
                if (dir == DIR_UP) begin
                    stepped[i*DIGIT_W +: DIGIT_W] = (cur == MAX_DIGIT) ? '0 : cur + 1'b1;
                    carry = (cur == MAX_DIGIT);
                end else begin
                    stepped[i*DIGIT_W +: DIGIT_W] = (cur == '0) ? MAX_DIGIT : cur - 1'b1;
                    carry = (cur == '0);
                end
            end
            if (load_val[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
                loaded[i*DIGIT_W +: DIGIT_W] = MAX_DIGIT;
            end
        end
    end

    assign at_limit = (dir == DIR_UP) ? all_max : all_zero;

`ifdef UPDOWN_SATURATE_EN
    assign hold = sat_mode & at_limit;
`else
    assign hold = 1'b0;
`endif

    // Load outranks the prescaler terminal, so a coincident step is dropped
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = loaded;
            presc_d = '0;
        end else if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                wrap_d  = at_limit;
                if (!hold) begin
                    count_d = stepped;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .digit (count_q[g*DIGIT_W +: DIGIT_W]),
            .seg   (seg[g*7 +: 7])
        );
    end

endmodule

// File: tb/tb_bcd_updown_display_counter.sv
// Directed bench: two-digit decimal and hex counters (DIV_COUNT=4) driven in parallel.
module tb_bcd_updown_display_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dir;
    logic        load;
    logic [7:0]  load_val;
`ifdef UPDOWN_SATURATE_EN
    logic        sat_mode;
`endif
    logic [7:0]  count10, count16;
    logic        tick10, tick16;
    logic        wrap10, wrap16;
    logic [13:0] seg10, seg16;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    bcd_updown_display_counter #(.DIGITS(2), .RADIX(10), .DIV_COUNT(4)) dut10 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
`ifdef UPDOWN_SATURATE_EN
        .sat_mode (sat_mode),
`endif
        .load     (load),
        .load_val (load_val),
        .count    (count10),
        .tick     (tick10),
        .wrap     (wrap10),
        .seg      (seg10)
    );

    bcd_updown_display_counter #(.DIGITS(2), .RADIX(16), .DIV_COUNT(4)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
`ifdef UPDOWN_SATURATE_EN
        .sat_mode (sat_mode),
`endif
        .load     (load),
        .load_val (load_val),
        .count    (count16),
        .tick     (tick16),
        .wrap     (wrap16),
        .seg      (seg16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [7:0] lv, input logic e, input logic d);
        load     = l;
        load_val = lv;
        en       = e;
        dir      = d;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
`ifdef UPDOWN_SATURATE_EN
        sat_mode = 1'b0;
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cycles(2);
        checkOutput("reset count", count10, 8'h00);
        checkOutput("reset tick", tick10, 1'b0);
        checkOutput("reset wrap", wrap10, 1'b0);
        checkOutput("reset seg", seg10, {7'b1000000, 7'b1000000});
        rst = 1'b1;

        // Free-run up: tick every 4th clock, count 01..03
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            cycles(1);
            checkOutput($sformatf("run tick k=%0d", k), tick10, (k % 4) == 0);
            checkOutput($sformatf("run count k=%0d", k), count10, k / 4);
            checkOutput($sformatf("run count16 k=%0d", k), count16, k / 4);
            if (k == 4) checkOutput("seg digit0 one", seg10[6:0], 7'b1111001);
        end

        // Load 98, step to 99 then wrap to 00
        applyStimulus(1'b1, 8'h98, 1'b1, 1'b1);
        cycles(1);
        checkOutput("load 98", count10, 8'h98);
        load = 1'b0;
        cycles(4);
        checkOutput("up to 99", count10, 8'h99);
        checkOutput("up to 99 wrap", wrap10, 1'b0);
        cycles(4);
        checkOutput("wrap count", count10, 8'h00);
        checkOutput("wrap pulse", wrap10, 1'b1);
        checkOutput("wrap tick", tick10, 1'b1);
        checkOutput("hex 9A", count16, 8'h9A);
        checkOutput("hex 9A wrap", wrap16, 1'b0);

        // Load 00 and count down: borrow through all digits
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        cycles(1);
        load = 1'b0;
        cycles(1);
        checkOutput("wrap one cycle", wrap10, 1'b0);
        cycles(3);
        checkOutput("down 99", count10, 8'h99);
        checkOutput("down wrap", wrap10, 1'b1);
        checkOutput("hex down FF", count16, 8'hFF);
        checkOutput("hex down wrap", wrap16, 1'b1);
        checkOutput("hex seg FF", seg16, {7'b0001110, 7'b0001110});
        checkOutput("dec seg 99", seg10, {7'b0010000, 7'b0010000});

        // Out-of-range load digits clamp in decimal only
        applyStimulus(1'b1, 8'hAF, 1'b1, 1'b0);
        cycles(1);
        checkOutput("clamp AF", count10, 8'h99);
        checkOutput("hex load AF", count16, 8'hAF);
        load = 1'b0;
        cycles(3);
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
        cycles(1);
        checkOutput("load at terminal tick", tick10, 1'b0);
        checkOutput("load at terminal count", count10, 8'h12);
        load = 1'b0;
        cycles(3);
        checkOutput("presc restarted", tick10, 1'b0);
        cycles(1);
        checkOutput("tick after load", tick10, 1'b1);
        checkOutput("down 11", count10, 8'h11);

        // Freeze mid-interval with en low
        cycles(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            checkOutput($sformatf("freeze count k=%0d", k), count10, 8'h11);
            checkOutput($sformatf("freeze tick k=%0d", k), tick10, 1'b0);
        end
        en = 1'b1;
        cycles(1);
        checkOutput("resume no tick", tick10, 1'b0);
        cycles(1);
        checkOutput("resume tick", tick10, 1'b1);
        checkOutput("resume count", count10, 8'h10);
        checkOutput("resume count16", count16, 8'h10);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        checkOutput("async rst count", count10, 8'h00);
        checkOutput("async rst count16", count16, 8'h00);
        checkOutput("async rst seg", seg10, {7'b1000000, 7'b1000000});
        cycles(1);
        rst = 1'b1;

`ifdef UPDOWN_SATURATE_EN
        sat_mode = 1'b1;
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        cycles(1);
        load = 1'b0;
        cycles(4);
        checkOutput("sat up count", count10, 8'h99);
        checkOutput("sat up wrap", wrap10, 1'b1);
        checkOutput("sat hex not at max", count16, 8'h9A);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        cycles(1);
        load = 1'b0;
        cycles(4);
        checkOutput("sat down count", count10, 8'h00);
        checkOutput("sat down wrap", wrap10, 1'b1);
        checkOutput("sat hex down count", count16, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
